// File: rtl/serial_tx.sv
// serial_tx: valid/ready word in, start + LSB-first data (+ even parity with SERIAL_TX_PARITY_EN) + stop out on tx_line.
// tx_line falls the cycle after the handshake; ready only in IDLE or the last STOP cycle (no queue, producer holds).
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              line_q, line_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic              hs;
  logic              bit_end;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    hs      = tx_valid & ready_q;
    bit_end = (div_q == DIV_LAST);
    shifted = shift_q >> 1;
    div_d   = bit_end ? '0 : div_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        div_d = '0;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            line_d  = parity_q;
`else
            state_d = STOP;
            line_d  = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shifted;
            line_d  = shifted[0];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          line_d  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ready_q is only high in IDLE or the last STOP cycle, so hs covers both entry points
    if (hs) begin
      state_d = START;
      shift_d = tx_data;
      line_d  = 1'b0;
      div_d   = '0;
      bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = ^tx_data;
`endif
    end

    ready_d = (state_d == IDLE) || ((state_d == STOP) && (div_d == DIV_LAST));
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_line  = line_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule
